// File: rtl/upg_load_sequencer.sv
// ============================================================================
// upg_load_sequencer: UART programming load sequencer (start debounce, CPU /
// UPG reset ownership, IMEM/DMEM write steering, load word counters)
// Revision: 1.0
// ============================================================================
`default_nettype none

module upg_load_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter int RESET_STRETCH   = 8
) (
  input  logic        iFpgaClk,
  input  logic        iFpgaRst,
  input  logic        iStartReceiveCoe,
  input  logic        iUpgWen,
  input  logic [14:0] iUpgAdr,
  input  logic        iUpgDone,
  output logic        oUpgReset,
  output logic        oCpuReset,
  output logic        oImemWen,
  output logic        oDmemWen,
  output logic        oLoading,
  output logic        oError,
  output logic [15:0] oImemWords,
  output logic [15:0] oDmemWords
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;
  localparam int STR_W = (RESET_STRETCH   > 1) ? $clog2(RESET_STRETCH)   : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(RESET_STRETCH - 1);
  localparam logic [15:0]      WORDS_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_LOAD     = 3'd2,
    ST_STRETCH  = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               start_meta_q, start_sync_q, start_sync_dly_q;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [STR_W-1:0]   str_cnt_q, str_cnt_d;
  logic [15:0]        imem_words_q, imem_words_d;
  logic [15:0]        dmem_words_q, dmem_words_d;
  logic               start_rise;
  logic               unused_adr;

  assign start_rise = start_sync_q & ~start_sync_dly_q;
  assign unused_adr = ^iUpgAdr[13:0];

  always_ff @(posedge iFpgaClk or posedge iFpgaRst) begin
    if (iFpgaRst) begin
      state_q          <= ST_STRETCH;
      start_meta_q     <= 1'b0;
      start_sync_q     <= 1'b0;
      start_sync_dly_q <= 1'b0;
      deb_cnt_q        <= '0;
      to_cnt_q         <= '0;
      str_cnt_q        <= STR_LAST;
      imem_words_q     <= '0;
      dmem_words_q     <= '0;
    end else begin
      state_q          <= state_d;
      start_meta_q     <= iStartReceiveCoe;
      start_sync_q     <= start_meta_q;
      start_sync_dly_q <= start_sync_q;
      deb_cnt_q        <= deb_cnt_d;
      to_cnt_q         <= to_cnt_d;
      str_cnt_q        <= str_cnt_d;
      imem_words_q     <= imem_words_d;
      dmem_words_q     <= dmem_words_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    to_cnt_d     = to_cnt_q;
    str_cnt_d    = str_cnt_q;
    imem_words_d = imem_words_q;
    dmem_words_d = dmem_words_q;
    oImemWen     = 1'b0;
    oDmemWen     = 1'b0;

    case (state_q)
      ST_RUN, ST_ERROR: begin
        if (start_rise) begin
          state_d   = ST_DEBOUNCE;
          deb_cnt_d = '0;
        end
      end
      ST_DEBOUNCE: begin
        // A release before the count completes always lands in RUN, even from ERROR.
        if (!start_sync_q) begin
          state_d = ST_RUN;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d      = ST_LOAD;
          to_cnt_d     = '0;
          imem_words_d = '0;
          dmem_words_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        oImemWen = iUpgWen & ~iUpgAdr[14];
        oDmemWen = iUpgWen &  iUpgAdr[14];
        if (oImemWen && imem_words_q != WORDS_MAX) imem_words_d = imem_words_q + 16'd1;
        if (oDmemWen && dmem_words_q != WORDS_MAX) dmem_words_d = dmem_words_q + 16'd1;
        to_cnt_d = iUpgWen ? '0 : to_cnt_q + 1'b1;
        // Done wins over timeout; a write in the done cycle is still counted above.
        if (iUpgDone) begin
          state_d   = ST_STRETCH;
          str_cnt_d = STR_LAST;
        end else if (!iUpgWen && to_cnt_q == TO_LAST) begin
          state_d = ST_ERROR;
        end
      end
      ST_STRETCH: begin
        if (str_cnt_q == '0) state_d = ST_RUN;
        else                 str_cnt_d = str_cnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    oCpuReset = 1'b1;
    oUpgReset = 1'b1;
    oLoading  = 1'b0;
    oError    = 1'b0;
    case (state_q)
      ST_RUN, ST_DEBOUNCE: oCpuReset = 1'b0;
      ST_LOAD: begin
        oUpgReset = 1'b0;
        oLoading  = 1'b1;
      end
      ST_ERROR: oError = 1'b1;
      default: ;
    endcase
  end

  assign oImemWords = imem_words_q;
  assign oDmemWords = dmem_words_q;

endmodule

`default_nettype wire

// File: doc/upg_load_sequencer.md
# upg_load_sequencer

Top-level sequencer for the UART programming (UPG) path. It debounces the start-receive button and owns the UART programmer reset. It holds the CPU in reset while a program image loads, and routes each UPG word write to instruction or data memory by address bit 14. On load completion it releases the CPU after a reset stretch. On a stalled transfer it parks in an error state. It replaces the ad-hoc upg_rst/kick-off logic in the CPU top and exposes word counters for display on the tubes.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive high cycles of synchronized start needed to enter loading
- TIMEOUT_CYCLES, 50_000_000, idle cycles in LOAD (no write, no done) before error
- RESET_STRETCH, 8, cycles CPU reset is held after reset release or load completion
- iFpgaClk  in  1  single clock; all inputs synchronous to it except iStartReceiveCoe
- iFpgaRst  in  1  reset, asynchronous, active-high
- iStartReceiveCoe  in  1  start button, asynchronous; 2-flop synchronized internally
- iUpgWen  in  1  UART programmer word-write strobe
- iUpgAdr  in  15  UART programmer word address; bit 14 = 1 selects data memory
- iUpgDone  in  1  UART programmer transfer-complete level
- oUpgReset  out  1  reset to UART programmer IP, active-high
- oCpuReset  out  1  reset to CPU datapath, active-high
- oImemWen  out  1  instruction-memory UPG write enable
- oDmemWen  out  1  data-memory UPG write enable
- oLoading  out  1  high while in LOAD
- oError  out  1  high while in ERROR
- oImemWords  out  16  saturating count of instruction words written in last load
- oDmemWords  out  16  saturating count of data words written in last load

## Operation
- States: RUN, DEBOUNCE, LOAD, STRETCH, ERROR. Reset state is STRETCH with stretch counter = RESET_STRETCH-1.
- Start edge: sStart = 2-flop synchronized input. rise = sStart & ~sStart_d.
- RUN: oCpuReset=0, oUpgReset=1. rise -> DEBOUNCE.
- DEBOUNCE: CPU keeps running (oCpuReset=0), oUpgReset=1. Counter counts cycles with sStart=1. sStart=0 -> RUN. Count reaches DEBOUNCE_CYCLES-1 with sStart=1 -> LOAD.
- Entry to LOAD clears oImemWords, oDmemWords, and the timeout counter.
- LOAD: oCpuReset=1, oUpgReset=0, oLoading=1.
  - oImemWen = iUpgWen & ~iUpgAdr[14]. oDmemWen = iUpgWen & iUpgAdr[14]. Both are combinational, gated by state==LOAD.
  - Each write increments the matching counter, saturating at 16'hFFFF.
  - Timeout counter clears on any iUpgWen and increments otherwise. Reaching TIMEOUT_CYCLES-1 with no write and no done -> ERROR.
  - iUpgDone=1 -> STRETCH with counter = RESET_STRETCH-1. A write in the same cycle is still passed through and counted.
- STRETCH: oCpuReset=1, oUpgReset=1. Counter decrements; at 0 -> RUN.
- ERROR: oCpuReset=1, oUpgReset=1, oError=1, counters hold. rise -> DEBOUNCE.
  - A failed debounce returns to RUN, not ERROR. A failed debounce is a deliberate user re-press and releases the CPU.
- Outside LOAD: oImemWen=oDmemWen=0. iUpgWen and iUpgDone are ignored and counters hold.
- Start held continuously after a load does not re-arm. A new rise is required.
- Start activity in LOAD or STRETCH is ignored.

## Timing
- Reset values while iFpgaRst=1: state STRETCH, oCpuReset=1, oUpgReset=1, oImemWen=0, oDmemWen=0, oLoading=0, oError=0, counters 0, synchronizer flops 0.
- After iFpgaRst falls, oCpuReset stays 1 for exactly RESET_STRETCH cycles, then 0.
- All outputs except oImemWen and oDmemWen are registered, Moore outputs of the state.
- Start latency: input rise to DEBOUNCE is 3 edges. DEBOUNCE to LOAD is DEBOUNCE_CYCLES cycles.
- iUpgDone sampled in LOAD gives oCpuReset=1 for RESET_STRETCH further cycles, then 0.
- iFpgaRst mid-load aborts immediately (asynchronous). Counters clear and the sequence follows the reset-release rule.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, RESET_STRETCH=3.
- Reset release -> oCpuReset=1 for exactly 3 cycles, then 0. oUpgReset=1 throughout. State RUN.
- Start high 2 synchronized cycles then low -> DEBOUNCE then RUN. oCpuReset never asserts. oLoading stays 0.
- Start held 10 cycles -> LOAD after 4 DEBOUNCE cycles, oUpgReset=0, oCpuReset=1. Then 5 writes at adr 0x0000..0x0004 and 3 writes at 0x4000..0x4002 -> oImemWen pulses 5, oDmemWen pulses 3, oImemWords=5, oDmemWords=3.
- iUpgDone asserted in the same cycle as the final write at 0x4003 -> write is passed, oDmemWords=4, oCpuReset drops 3 cycles later. Start still held gives no re-entry.
- LOAD with no writes for 100 cycles -> oError=1, oCpuReset=1, oUpgReset=1. Then iUpgWen=1 gives no enables. A new start press of 4+ cycles returns to LOAD with counters cleared.
- iFpgaRst pulse mid-load after 7 writes -> counters 0 and oLoading=0 immediately, oCpuReset held 3 cycles after release, then state RUN.
